// File: rtl/gs_div_fixup_pkg.sv
// +----------------------------------------------------------------------+
// | gs_div_fixup_pkg : shared widths, limits and FSM encoding             |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package gs_div_fixup_pkg;

  localparam int I_BITS  = 32;
  localparam int F_BITS  = 40;
  localparam int T_BITS  = I_BITS + F_BITS;
  localparam int MAX_FIX = 3;
  localparam int RW      = 2 * I_BITS + 2;
  localparam int CNT_W   = $clog2(MAX_FIX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CHK  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gs_div_fixup_if.sv
// +----------------------------------------------------------------------+
// | gs_div_fixup_if : divider-side capture inputs and result handshake    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface gs_div_fixup_if;
  import gs_div_fixup_pkg::*;

  logic              div_done;
  logic [T_BITS-1:0] div_n;
  logic [T_BITS-1:0] div_d;
  logic [T_BITS-1:0] div_q;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [I_BITS-1:0] quot;
  logic [I_BITS-1:0] rem;
  logic              dz;
  logic              err;

  modport master (
    output div_done, div_n, div_d, div_q, out_ready,
    input  busy, out_valid, quot, rem, dz, err
  );

  modport slave (
    input  div_done, div_n, div_d, div_q, out_ready,
    output busy, out_valid, quot, rem, dz, err
  );

endinterface

`default_nettype wire

// File: rtl/gs_div_fixup.sv
// +----------------------------------------------------------------------+
// | gs_div_fixup : exact integer quotient/remainder from Goldschmidt q    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module gs_div_fixup
  import gs_div_fixup_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  gs_div_fixup_if.slave bus
);

  state_t            r_state;
  logic              r_done_q;
  logic [I_BITS-1:0] r_n;
  logic [I_BITS-1:0] r_d;
  logic [I_BITS:0]   r_q;
  logic signed [RW-1:0] r_r;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic [I_BITS-1:0] r_quot;
  logic [I_BITS-1:0] r_rem;
  logic              r_dz;
  logic              r_err;

  logic [I_BITS-1:0]    w_n;
  logic [I_BITS-1:0]    w_d;
  logic [I_BITS-1:0]    w_q0;
  logic                 w_start;
  logic [2*I_BITS:0]    w_prod;
  logic signed [RW-1:0] w_r_mul;
  logic signed [RW-1:0] w_d_ext;
  logic                 w_unused_frac;

  assign w_n  = bus.div_n[T_BITS-1:F_BITS];
  assign w_d  = bus.div_d[T_BITS-1:F_BITS];
  assign w_q0 = bus.div_q[T_BITS-1:F_BITS];
  assign w_unused_frac = ^{bus.div_n[F_BITS-1:0], bus.div_d[F_BITS-1:0],
                           bus.div_q[F_BITS-1:0]};

  // Only a fresh rising edge of done starts work; edges while busy are dropped.
  assign w_start = bus.div_done & ~r_done_q & (r_state == ST_IDLE);

  assign w_prod  = {{I_BITS{1'b0}}, r_q} * {{(I_BITS + 1){1'b0}}, r_d};
  assign w_r_mul = $signed({{(I_BITS + 2){1'b0}}, r_n}) - $signed({1'b0, w_prod});
  assign w_d_ext = $signed({{(I_BITS + 2){1'b0}}, r_d});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_done_q <= 1'b0;
      r_n      <= '0;
      r_d      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done_q <= bus.div_done;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_n    <= w_n;
            r_d    <= w_d;
            r_q    <= {1'b0, w_q0};
            r_cnt  <= '0;
            r_dz   <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (w_d == '0) begin
              r_quot  <= '1;
              r_rem   <= w_n;
              r_dz    <= 1'b1;
              r_valid <= 1'b1;
              r_state <= ST_OUT;
            end else begin
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_r     <= w_r_mul;
          r_state <= ST_CHK;
        end
        ST_CHK: begin
          if (r_cnt == CNT_W'(MAX_FIX)) begin
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_OUT;
          end else if (r_r[RW-1]) begin
            // Decrementing from zero wraps q; flag it so it survives later +1 steps.
            if (r_q == '0) begin
              r_err <= 1'b1;
            end
            r_q   <= r_q - (I_BITS + 1)'(1);
            r_r   <= r_r + w_d_ext;
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (r_r >= w_d_ext) begin
            r_q   <= r_q + (I_BITS + 1)'(1);
            r_r   <= r_r - w_d_ext;
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_quot  <= r_q[I_BITS-1:0];
            r_rem   <= r_r[I_BITS-1:0];
            r_err   <= r_err | r_q[I_BITS];
            r_valid <= 1'b1;
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.quot      = r_quot;
  assign bus.rem       = r_rem;
  assign bus.dz        = r_dz;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gs_div_fixup.sv
// +----------------------------------------------------------------------+
// | tb_gs_div_fixup : randomized self-checking bench for gs_div_fixup     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gs_div_fixup;
  import gs_div_fixup_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  gs_div_fixup_if bus ();

  gs_div_fixup dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  function automatic logic [T_BITS-1:0] fx(input logic [31:0] v);
    logic [63:0] rnd;
    rnd = {$urandom(), $urandom()};
    return {v, rnd[F_BITS-1:0]};
  endfunction

  // Closed-form expectation: exact floor division, and the fix-up needs
  // |q0 - floor(n/d)| unit steps; reaching MAX_FIX steps is an error.
  function automatic void model(input logic [31:0] n, d, q0,
                                output logic [31:0] eq, er,
                                output logic edz, eerr, output int elat);
    longint qt, steps;
    if (d == 0) begin
      eq = 32'hFFFF_FFFF; er = n; edz = 1'b1; eerr = 1'b0; elat = 1;
    end else begin
      qt    = longint'(n) / longint'(d);
      er    = 32'(longint'(n) % longint'(d));
      steps = (longint'(q0) > qt) ? longint'(q0) - qt : qt - longint'(q0);
      edz   = 1'b0;
      if (steps >= MAX_FIX) begin
        eq = '0; er = '0; eerr = 1'b1; elat = 3 + MAX_FIX;
      end else begin
        eq = 32'(qt); eerr = 1'b0; elat = 3 + int'(steps);
      end
    end
  endfunction

  task automatic start_op(input logic [31:0] n, d, q0);
    bus.div_n    = fx(n);
    bus.div_d    = fx(d);
    bus.div_q    = fx(q0);
    bus.div_done = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.out_valid) begin
        bus.div_n = fx($urandom());
        bus.div_d = fx($urandom());
        bus.div_q = fx($urandom());
      end
    end while (!bus.out_valid && lat < 30);
  endtask

  task automatic do_op(input logic [31:0] n, d, q0, input int hold,
                       output logic [31:0] q, r, output logic dz, err,
                       output int lat);
    @(negedge clk);
    start_op(n, d, q0);
    wait_valid(lat);
    q = bus.quot; r = bus.rem; dz = bus.dz; err = bus.err;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.div_done  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.dz, bus.err} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {bus.out_valid, bus.busy, bus.dz, bus.err});
    else n_pass++;
    n_checks++;
    if (bus.quot !== 32'd0) $display("FAIL reset_quot: got %0h expected 0", bus.quot);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rem !== 32'd0 || bus.busy !== 1'b0)
      $display("FAIL reset_release: got rem=%0h busy=%b expected 0/0", bus.rem, bus.busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] q0s [4] = '{32'd14, 32'd13, 32'd16, 32'd20};
    logic [31:0] eq, er, q, r;
    logic edz, eerr, dz, err;
    int elat, lat;
    for (int i = 0; i < 4; i++) begin
      model(32'd100, 32'd7, q0s[i], eq, er, edz, eerr, elat);
      do_op(32'd100, 32'd7, q0s[i], i, q, r, dz, err, lat);
      n_checks++;
      if (lat !== elat) $display("FAIL basic_lat q0=%0d: got %0d expected %0d", q0s[i], lat, elat);
      else n_pass++;
      n_checks++;
      if ({dz, err} !== {edz, eerr}) $display("FAIL basic_flags q0=%0d: got %b expected %b", q0s[i], {dz, err}, {edz, eerr});
      else n_pass++;
      if (!eerr) begin
        n_checks++;
        if ({q, r} !== {eq, er}) $display("FAIL basic_qr q0=%0d: got %0d/%0d expected %0d/%0d", q0s[i], q, r, eq, er);
        else n_pass++;
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    @(negedge clk);
    start_op(32'd5, 32'd0, 32'd77);
    wait_valid(lat);
    n_checks++;
    if (lat !== 1) $display("FAIL dz_lat: got %0d expected 1", lat);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.quot, bus.rem, bus.dz, bus.err} !== {1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0})
        $display("FAIL dz_hold cycle %0d: got v=%b q=%0h r=%0h dz=%b err=%b expected 1/ffffffff/5/1/0",
                 k, bus.out_valid, bus.quot, bus.rem, bus.dz, bus.err);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL dz_transfer: got valid=%b expected 0", bus.out_valid);
    else n_pass++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.busy, bus.out_valid} !== 2'b00)
        $display("FAIL dz_no_retrigger cycle %0d: got busy/valid=%b expected 00", k, {bus.busy, bus.out_valid});
      else n_pass++;
    end
    @(negedge clk);
    bus.div_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic dz, err;
    int lat;
    @(negedge clk);
    start_op(32'd100, 32'd7, 32'd20);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.div_done = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.dz, bus.err, bus.quot, bus.rem} !== '0)
      $display("FAIL mid_reset: got v=%b b=%b dz=%b err=%b q=%0h r=%0h expected all 0",
               bus.out_valid, bus.busy, bus.dz, bus.err, bus.quot, bus.rem);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_op(32'd1000, 32'd10, 32'd100, 0, q, r, dz, err, lat);
    n_checks++;
    if ({q, r, dz, err} !== {32'd100, 32'd0, 1'b0, 1'b0} || lat !== 3)
      $display("FAIL after_reset_op: got q=%0d r=%0d dz=%b err=%b lat=%0d expected 100/0/0/0/3", q, r, dz, err, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] n1, d1, n2, d2, eq, er;
    logic edz, eerr;
    int lat, elat;
    n1 = $urandom(); d1 = $urandom_range(1, 1000);
    n2 = $urandom(); d2 = $urandom_range(1, 1000);
    @(negedge clk);
    start_op(n1, d1, n1 / d1);
    wait_valid(lat);
    @(negedge clk);
    bus.div_done  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) $display("FAIL b2b_transfer: got busy/valid=%b expected 00", {bus.busy, bus.out_valid});
    else n_pass++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    model(n2, d2, n2 / d2, eq, er, edz, eerr, elat);
    start_op(n2, d2, n2 / d2);
    wait_valid(lat);
    n_checks++;
    if (lat !== elat || {bus.quot, bus.rem, bus.dz, bus.err} !== {eq, er, edz, eerr})
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d", lat, bus.quot, bus.rem, elat, eq, er);
    else n_pass++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.div_done  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] n, d, q0, eq, er, q, r;
    logic edz, eerr, dz, err;
    int elat, lat;
    longint qt, q0l;
    for (int i = 0; i < 40; i++) begin
      n = $urandom();
      case ($urandom_range(0, 7))
        0:       d = 32'd0;
        1, 2, 3: d = $urandom_range(1, 20);
        default: d = $urandom() >> $urandom_range(0, 31);
      endcase
      if (d == 0) d = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd3;
      qt  = (d == 0) ? 0 : longint'(n) / longint'(d);
      q0l = qt + longint'($urandom_range(0, 8)) - 4;
      if (q0l < 0) q0l = 0;
      if (q0l > 64'hFFFF_FFFF) q0l = 64'hFFFF_FFFF;
      q0 = 32'(q0l);
      model(n, d, q0, eq, er, edz, eerr, elat);
      do_op(n, d, q0, $urandom_range(0, 3), q, r, dz, err, lat);
      n_checks++;
      if (lat !== elat) $display("FAIL rand_lat n=%0d d=%0d q0=%0d: got %0d expected %0d", n, d, q0, lat, elat);
      else n_pass++;
      n_checks++;
      if ({dz, err} !== {edz, eerr}) $display("FAIL rand_flags n=%0d d=%0d q0=%0d: got %b expected %b", n, d, q0, {dz, err}, {edz, eerr});
      else n_pass++;
      if (!eerr) begin
        n_checks++;
        if ({q, r} !== {eq, er}) $display("FAIL rand_qr n=%0d d=%0d q0=%0d: got %0d/%0d expected %0d/%0d", n, d, q0, q, r, eq, er);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.div_done  = 1'b0;
    bus.div_n     = '0;
    bus.div_d     = '0;
    bus.div_q     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
